// File: rtl/cpu_pkg.sv
// Constants shared by the fetch and decode stages: widths, reset PC, opcode
// field layout and the unconditional-jump encoding.
package cpu_pkg;

    localparam int unsigned INST_W = 32;
    localparam int unsigned ADDR_W = 32;

    localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    localparam int unsigned OPC_MSB    = 31;
    localparam int unsigned OPC_LSB    = 26;
    localparam int unsigned JFIELD_MSB = 25;
    localparam int unsigned JFIELD_LSB = 0;

    localparam logic [OPC_MSB-OPC_LSB:0] OPC_JUMP = 6'b010010;

    // Word-aligned address mask; the two byte-offset bits are always zero.
    localparam logic [ADDR_W-1:0] WORD_MASK = ~32'h0000_0003;

    function automatic logic is_jump(input logic [INST_W-1:0] inst);
        return inst[OPC_MSB:OPC_LSB] == OPC_JUMP;
    endfunction

    function automatic logic [ADDR_W-1:0] jump_target(input logic [ADDR_W-1:0] pc,
                                                      input logic [INST_W-1:0] inst);
        return {pc[ADDR_W-1:28], inst[JFIELD_MSB:JFIELD_LSB], 2'b00};
    endfunction

endpackage

// File: rtl/inst_fetch.sv
// Instruction fetch: owns the PC, addresses the combinational ROM and feeds
// decode through a valid/ready register slice. Jumps resolve here.
module inst_fetch
    import cpu_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [INST_W-1:0] rom_inst,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [INST_W-1:0] out_inst,
    output logic [ADDR_W-1:0] out_pc,
    output logic [31:0]       fetch_count
);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              valid_q, valid_d;
    logic [INST_W-1:0] inst_q, inst_d;
    logic [ADDR_W-1:0] opc_q, opc_d;
    logic [31:0]       count_q, count_d;
    logic              load;

    assign load = !valid_q || out_ready;

    // Redirect outranks the slice load, so a jump in rom_inst that cycle is lost.
    always_comb begin
        pc_d    = pc_q;
        valid_d = valid_q;
        inst_d  = inst_q;
        opc_d   = opc_q;
        if (redirect_valid) begin
            pc_d    = redirect_pc & WORD_MASK;
            valid_d = 1'b0;
        end else if (load) begin
            inst_d  = rom_inst;
            opc_d   = pc_q;
            valid_d = 1'b1;
            pc_d    = is_jump(rom_inst) ? jump_target(pc_q, rom_inst) : pc_q + 32'd4;
        end
    end

    // A handoff is counted even when a redirect squashes the slice that cycle.
    assign count_d = (valid_q && out_ready) ? count_q + 32'd1 : count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= RESET_PC;
            valid_q <= 1'b0;
            inst_q  <= '0;
            opc_q   <= '0;
            count_q <= '0;
        end else begin
            pc_q    <= pc_d;
            valid_q <= valid_d;
            inst_q  <= inst_d;
            opc_q   <= opc_d;
            count_q <= count_d;
        end
    end

    assign rom_addr    = pc_q;
    assign out_valid   = valid_q;
    assign out_inst    = inst_q;
    assign out_pc      = opc_q;
    assign fetch_count = count_q;

endmodule
